// File: rtl/systolic_pkg.sv
// Shared types and helpers for the output-stationary systolic matrix-multiply engine.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    FLUSH,
    DRAIN
  } state_e;

  // Number of bits an operand must be widened by to reach the accumulator width.
  function automatic int extWidth(input int accw, input int dw);
    return accw - dw;
  endfunction

endpackage

// File: rtl/systolic_matmul_engine_pe.sv
// One processing element: registers operands flowing right/down and accumulates their product.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DW     = 8,
  parameter int ACCW   = 24,
  parameter bit SIGNED = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en_i,
  input  logic            clear_i,
  input  logic [DW-1:0]   a_i,
  input  logic [DW-1:0]   b_i,
  output logic [DW-1:0]   a_o,
  output logic [DW-1:0]   b_o,
  output logic [ACCW-1:0] acc_o
);

  localparam int EXTW = extWidth(ACCW, DW);

  logic [DW-1:0]   a_q, b_q;
  logic [ACCW-1:0] acc_q, acc_d;
  logic [ACCW-1:0] aExt, bExt;
  logic            signA, signB;

  // Widening to ACCW before multiplying makes the product wrap modulo 2^ACCW in both modes.
  always_comb begin
    signA = SIGNED && a_i[DW-1];
    signB = SIGNED && b_i[DW-1];
    aExt  = {{EXTW{signA}}, a_i};
    bExt  = {{EXTW{signB}}, b_i};
    acc_d = acc_q + aExt * bExt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (clear_i) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (en_i) begin
      a_q   <= a_i;
      b_q   <= b_i;
      acc_q <= acc_d;
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/systolic_matmul_engine.sv
// N x N output-stationary systolic engine computing C = A*B with run-time K and handshaked I/O.
module systolic_matmul_engine
  import systolic_pkg::*;
#(
  parameter int N      = 3,
  parameter int DW     = 8,
  parameter int ACCW   = 24,
  parameter int KMAX   = 255,
  parameter bit SIGNED = 1'b0,
  localparam int KW    = $clog2(KMAX + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [KW-1:0]     k_len,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*DW-1:0]   a_col,
  input  logic [N*DW-1:0]   b_row,
  output logic              c_valid,
  input  logic              c_ready,
  output logic [N*ACCW-1:0] c_data,
  output logic              c_last,
  output logic              done
);

  localparam int FW = $clog2(2 * N - 1);
  localparam int RW = $clog2(N);

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [KW-1:0]   kCnt_q, kCnt_d;
  logic [FW-1:0]   flushCnt_q, flushCnt_d;
  logic [RW-1:0]   row_q, row_d;
  logic            done_q, done_d;

  logic            feeding, adv, clear;
  logic [DW-1:0]   aSkew [N];
  logic [DW-1:0]   bSkew [N];
  logic [DW-1:0]   aOut  [N][N];
  logic [DW-1:0]   bOut  [N][N];
  logic [ACCW-1:0] acc   [N][N];
  logic [2*N*DW-1:0] unusedEdgeOps;

  assign feeding = (state_q == FEED);
  assign adv     = (feeding && in_valid) || (state_q == FLUSH);
  assign clear   = (state_q == IDLE) && start;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    kCnt_d     = kCnt_q;
    flushCnt_d = flushCnt_q;
    row_d      = row_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          k_d        = (k_len > KW'(KMAX)) ? KW'(KMAX) : k_len;
          kCnt_d     = '0;
          flushCnt_d = '0;
          row_d      = '0;
          state_d    = (k_d == '0) ? DRAIN : FEED;
        end
      end
      FEED: begin
        if (in_valid) begin
          kCnt_d = kCnt_q + KW'(1);
          if (kCnt_q == k_q - KW'(1)) state_d = FLUSH;
        end
      end
      FLUSH: begin
        flushCnt_d = flushCnt_q + FW'(1);
        if (flushCnt_q == FW'(2 * N - 3)) state_d = DRAIN;
      end
      DRAIN: begin
        if (c_ready) begin
          if (row_q == RW'(N - 1)) begin
            row_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      k_q        <= '0;
      kCnt_q     <= '0;
      flushCnt_q <= '0;
      row_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      kCnt_q     <= kCnt_d;
      flushCnt_q <= flushCnt_d;
      row_q      <= row_d;
      done_q     <= done_d;
    end
  end

  // Row i of A and column i of B are delayed i advances; zeros enter once feeding stops.
  for (genvar i = 0; i < N; i++) begin : gSkew
    logic [DW-1:0] aNew, bNew;
    assign aNew = feeding ? a_col[i*DW +: DW] : '0;
    assign bNew = feeding ? b_row[i*DW +: DW] : '0;
    if (i == 0) begin : gDirect
      assign aSkew[i] = aNew;
      assign bSkew[i] = bNew;
    end else begin : gLine
      logic [DW-1:0] aLine_q [i];
      logic [DW-1:0] bLine_q [i];
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int d = 0; d < i; d++) begin
            aLine_q[d] <= '0;
            bLine_q[d] <= '0;
          end
        end else if (clear) begin
          for (int d = 0; d < i; d++) begin
            aLine_q[d] <= '0;
            bLine_q[d] <= '0;
          end
        end else if (adv) begin
          aLine_q[0] <= aNew;
          bLine_q[0] <= bNew;
          for (int d = 1; d < i; d++) begin
            aLine_q[d] <= aLine_q[d-1];
            bLine_q[d] <= bLine_q[d-1];
          end
        end
      end
      assign aSkew[i] = aLine_q[i-1];
      assign bSkew[i] = bLine_q[i-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : gRow
    for (genvar j = 0; j < N; j++) begin : gCol
      logic [DW-1:0] aIn, bIn;
      if (j == 0) begin : gAEdge
        assign aIn = aSkew[i];
      end else begin : gAInner
        assign aIn = aOut[i][j-1];
      end
      if (i == 0) begin : gBEdge
        assign bIn = bSkew[j];
      end else begin : gBInner
        assign bIn = bOut[i-1][j];
      end
      systolic_pe #(
        .DW    (DW),
        .ACCW  (ACCW),
        .SIGNED(SIGNED)
      ) uPe (
        .clk    (clk),
        .reset  (reset),
        .en_i   (adv),
        .clear_i(clear),
        .a_i    (aIn),
        .b_i    (bIn),
        .a_o    (aOut[i][j]),
        .b_o    (bOut[i][j]),
        .acc_o  (acc[i][j])
      );
    end
  end

  // Operands leaving the right and bottom edges of the array have no consumer.
  for (genvar e = 0; e < N; e++) begin : gEdgeSink
    assign unusedEdgeOps[e*DW +: DW]     = aOut[e][N-1];
    assign unusedEdgeOps[(N+e)*DW +: DW] = bOut[N-1][e];
  end

  always_comb begin
    c_data = '0;
    if (state_q == DRAIN) begin
      for (int r = 0; r < N; r++) begin
        if (row_q == RW'(r)) begin
          for (int j = 0; j < N; j++) c_data[j*ACCW +: ACCW] = acc[r][j];
        end
      end
    end
  end

  assign busy     = (state_q != IDLE);
  assign in_ready = feeding;
  assign c_valid  = (state_q == DRAIN);
  assign c_last   = (state_q == DRAIN) && (row_q == RW'(N - 1));
  assign done     = done_q;

endmodule
